life_counter: RTL and testbench

Saturating down-counter that tracks the player's remaining lives in Frogger. It consumes hit events from collision logic, decrements once per hit, and enforces an invulnerability window after each hit. It also latches a game-over condition when lives reach zero. The score path counts up; this block counts down and feeds the HUD digit and the game-control FSM.

---
 rtl/frogger_pkg.sv | 18 +
 rtl/rise_detect.sv | 24 ++
 rtl/life_counter.sv | 124 ++++++++++++
 tb/tb_life_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared Frogger game types and default constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frogger_pkg;

    // Life-tracking states shared by life_counter and the game-control FSM
    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        COOLDOWN  = 2'd1,
        GAME_OVER = 2'd2
    } life_state_t;

    // Default lives, bonus ceiling and invulnerability window length
    localparam int LIVES_START  = 3;
    localparam int LIVES_MAX    = 7;
    localparam int HIT_COOLDOWN = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level.
// Latency: combinational pulse, valid in the cycle the level first reads high.
// Backpressure: none; a level held high yields exactly one pulse.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_in_d;

    // History flop; clears to 0 so a level already high after reset counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_d <= 1'b0;
        end else begin
            r_in_d <= in;
        end
    end

    assign pulse = in & ~r_in_d;

endmodule

// File: rtl/life_counter.sv
// Saturating lives down-counter with post-hit invulnerability and game-over latch.
// Latency: one cycle from sampled hit/bonus edge to lives/invuln/game_over.
// Backpressure: none; events arriving during cooldown (hit) or game-over are dropped.
// Optional macro LIFE_BONUS_EN adds the bonus port (rising edge awards a life, capped at MAX).
module life_counter
    import frogger_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int START    = LIVES_START,
    parameter int MAX      = LIVES_MAX,
    parameter int COOLDOWN = HIT_COOLDOWN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
`ifdef LIFE_BONUS_EN
    input  logic             bonus,
`endif
    output logic [WIDTH-1:0] lives,
    output logic             invuln,
    output logic             game_over
);

    // The COOLDOWN parameter shadows the enum literal of the same name,
    // so the state literal is always referenced through the package scope.
    localparam int                CW         = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [WIDTH-1:0]  L_START    = WIDTH'(START);
    localparam logic [WIDTH-1:0]  L_MAX      = WIDTH'(MAX);
    localparam logic [CW-1:0]     L_CNT_LOAD = CW'(COOLDOWN - 1);

    life_state_t       r_state;
    logic [WIDTH-1:0]  r_lives;
    logic [CW-1:0]     r_cnt;

    life_state_t       w_state_nxt;
    logic [WIDTH-1:0]  w_lives_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [WIDTH-1:0]  w_lives_inc;
    logic              w_hit_e;
    logic              w_bonus_e;

    rise_detect u_hit_edge (
        .clk   (clk),
        .reset (reset),
        .in    (hit),
        .pulse (w_hit_e)
    );

`ifdef LIFE_BONUS_EN
    rise_detect u_bonus_edge (
        .clk   (clk),
        .reset (reset),
        .in    (bonus),
        .pulse (w_bonus_e)
    );
`else
    // Without bonus support the event never fires, so lives only ever decrement
    assign w_bonus_e = 1'b0;
`endif

    // Bonus increment that saturates at the ceiling instead of wrapping
    assign w_lives_inc = (r_lives >= L_MAX) ? L_MAX : r_lives + 1'b1;

    // State, lives and cooldown registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ALIVE;
            r_lives <= L_START;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: hit handling in ALIVE, cooldown countdown, absorbing game-over
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ALIVE: begin
                if (w_hit_e) begin
                    if (w_bonus_e) begin
                        // Hit and bonus cancel out but still trigger invulnerability
                        w_cnt_nxt   = L_CNT_LOAD;
                        w_state_nxt = frogger_pkg::COOLDOWN;
                    end else if (r_lives == WIDTH'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = GAME_OVER;
                    end else begin
                        w_lives_nxt = r_lives - 1'b1;
                        w_cnt_nxt   = L_CNT_LOAD;
                        w_state_nxt = frogger_pkg::COOLDOWN;
                    end
                end else if (w_bonus_e) begin
                    w_lives_nxt = w_lives_inc;
                end
            end
            frogger_pkg::COOLDOWN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ALIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                if (w_bonus_e) begin
                    w_lives_nxt = w_lives_inc;
                end
            end
            GAME_OVER: begin
                w_lives_nxt = '0;
            end
            default: begin
                w_state_nxt = ALIVE;
            end
        endcase
    end

    assign lives     = r_lives;
    assign invuln    = (r_state == frogger_pkg::COOLDOWN);
    assign game_over = (r_state == GAME_OVER);

endmodule

// File: tb/tb_life_counter.sv
// Directed bench for life_counter with default parameters.
// Vectors: one table entry per clock edge, inputs applied before the edge, outputs checked 1ns after.
// Multi-cycle corners (async reset, game-over run, bonus) are hand-written sequences.
module tb_life_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hit = 1'b0;
`ifdef LIFE_BONUS_EN
    logic       bonus = 1'b0;
`endif
    logic [2:0] lives;
    logic       invuln;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic       hit;
        logic [2:0] lives;
        logic       inv;
        logic       go;
    } vec_t;

    vec_t tbl[$];

    life_counter dut (
        .clk       (clk),
        .reset     (reset),
        .hit       (hit),
`ifdef LIFE_BONUS_EN
        .bonus     (bonus),
`endif
        .lives     (lives),
        .invuln    (invuln),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] el, input logic ei, input logic eg);
        checks++;
        if (lives !== el || invuln !== ei || game_over !== eg) begin
            errors++;
            $display("FAIL %s: got lives=%0d invuln=%b game_over=%b, want lives=%0d invuln=%b game_over=%b",
                     name, lives, invuln, game_over, el, ei, eg);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic h, input logic [2:0] l, input logic i, input logic g);
        vec_t v;
        v.rst = r; v.hit = h; v.lives = l; v.inv = i; v.go = g;
        tbl.push_back(v);
    endtask

    // Assert reset between edges, check it took effect at once, release after an edge
    task automatic async_reset(input string name);
        #3 reset = 1'b1;
        #1 chk(name, 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Reset applied before any clock edge
        #1 reset = 1'b1;
        #1 chk("reset_initial", 3'd3, 1'b0, 1'b0);
        step();
        reset = 1'b0;

        // Single hit, cooldown boundary, repeated hits, game-over, reset, held hit
        add(0, 0, 3'd3, 0, 0);
        add(0, 1, 3'd2, 1, 0);   // edge k
        add(0, 0, 3'd2, 1, 0);
        add(0, 0, 3'd2, 1, 0);
        add(0, 0, 3'd2, 1, 0);
        add(0, 1, 3'd2, 0, 0);   // k+4: invuln drops, this hit still ignored
        add(0, 0, 3'd2, 0, 0);
        add(0, 1, 3'd1, 1, 0);   // k+6: processed
        add(0, 0, 3'd1, 1, 0);
        add(0, 1, 3'd1, 1, 0);   // 2 cycles into cooldown: ignored
        add(0, 0, 3'd1, 1, 0);
        add(0, 0, 3'd1, 0, 0);
        add(0, 1, 3'd0, 0, 1);   // last life lost
        add(0, 0, 3'd0, 0, 1);
        add(0, 1, 3'd0, 0, 1);   // absorbed in game-over
        add(0, 0, 3'd0, 0, 1);
        add(1, 0, 3'd3, 0, 0);
        add(0, 0, 3'd3, 0, 0);
        for (int i = 0; i < 12; i++) begin
            add(0, 1, 3'd2, (i < 4) ? 1'b1 : 1'b0, 0);   // held level: one decrement
        end
        add(0, 0, 3'd2, 0, 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            hit   = tbl[i].hit;
            step();
            chk($sformatf("vec%0d", i), tbl[i].lives, tbl[i].inv, tbl[i].go);
        end
        reset = 1'b0;
        hit   = 1'b0;

        // Game over via three spaced pulses, then reset mid-run
        async_reset("reset_async_alive");
        for (int p = 0; p < 3; p++) begin
            hit = 1'b1;
            step();
            if (p == 2) chk("go_pulse", 3'd0, 1'b0, 1'b1);
            else        chk($sformatf("go_pulse%0d", p), 3'(2 - p), 1'b1, 1'b0);
            hit = 1'b0;
            repeat (5) step();
        end
        chk("go_settled", 3'd0, 1'b0, 1'b1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
        chk("go_hit_ignored", 3'd0, 1'b0, 1'b1);
`ifdef LIFE_BONUS_EN
        bonus = 1'b1;
        step();
        bonus = 1'b0;
        step();
        chk("go_bonus_ignored", 3'd0, 1'b0, 1'b1);
`endif
        async_reset("reset_from_game_over");
        chk("reset_released", 3'd3, 1'b0, 1'b0);

        // Reset in the middle of a cooldown window
        hit = 1'b1;
        step();
        chk("cd_hit", 3'd2, 1'b1, 1'b0);
        hit = 1'b0;
        step();
        step();
        async_reset("reset_mid_cooldown");
        chk("after_cd_reset", 3'd3, 1'b0, 1'b0);
        hit = 1'b1;
        step();
        chk("hit_after_reset", 3'd2, 1'b1, 1'b0);
        hit = 1'b0;
        repeat (5) step();
        chk("hit_after_reset_cd_end", 3'd2, 1'b0, 1'b0);

`ifdef LIFE_BONUS_EN
        // Bonus saturation, then simultaneous hit and bonus at one life
        async_reset("reset_bonus");
        for (int b = 0; b < 5; b++) begin
            bonus = 1'b1;
            step();
            chk($sformatf("bonus%0d", b), (b < 4) ? 3'(4 + b) : 3'd7, 1'b0, 1'b0);
            bonus = 1'b0;
            step();
        end
        async_reset("reset_simul");
        for (int h = 0; h < 2; h++) begin
            hit = 1'b1;
            step();
            hit = 1'b0;
            repeat (5) step();
        end
        chk("one_life", 3'd1, 1'b0, 1'b0);
        hit   = 1'b1;
        bonus = 1'b1;
        step();
        chk("simul_hit_bonus", 3'd1, 1'b1, 1'b0);
        hit   = 1'b0;
        bonus = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
